riscv_pipe_ctrl: RTL

//  Central hazard/flow controller for the 5-stage (IF/ID/EX/MEM/WB) RISC-V pipeline.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/sat_counter.sv | 23 ++
 rtl/riscv_pipe_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the pipeline flow controller.
//   pipe_state_t : controller state (RUN / DRAIN / HALTED)
//   fwd_sel_t    : EX operand source select (register file / MEM ALU result / WB data)
package riscv_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } pipe_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk  : rising-edge clock
//   rst  : synchronous active-high clear
//   inc  : count this cycle
//   q    : current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Hazard / flow controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Inputs : clk, rst (sync, active-high); ID sources rs1_d/rs2_d with use flags and
//          halt_d; EX sources rs1_e/rs2_e; per-stage rd_x/wr_x; load_e; br_taken_e;
//          mem_stall (freezes everything).
// Outputs: pc_wr_en/pc_sel_target; per-register write enables and flushes;
//          fwd_a_sel/fwd_b_sel; stage valid bits; ohalt; four saturating counters;
//          state_dbg (current controller state).
// Enable semantics: a pipeline register loads on a rising edge only when its
// *_wr_en is high; if the matching *_flush is also high it loads a bubble
// (valid=0, control=0) instead of the upstream stage.
module riscv_pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  use_rs1_d,
  input  logic                  use_rs2_d,
  input  logic                  halt_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  wr_e,
  input  logic                  wr_m,
  input  logic                  wr_w,
  input  logic                  load_e,
  input  logic                  br_taken_e,
  input  logic                  mem_stall,
  output logic                  pc_wr_en,
  output logic                  pc_sel_target,
  output logic                  if_id_wr_en,
  output logic                  id_ex_wr_en,
  output logic                  ex_mem_wr_en,
  output logic                  mem_wb_wr_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  valid_d,
  output logic                  valid_e,
  output logic                  valid_m,
  output logic                  valid_w,
  output logic                  ohalt,
  output logic [CNT_W-1:0]      cyc_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [1:0]            state_dbg
);

  localparam bit FWD_ON = (FWD_EN != 0);

  pipe_state_t state;
  // Marks which stage currently holds the HALT instruction during drain.
  logic halt_e, halt_m, halt_w;

  logic prod_e, prod_m, prod_w;
  logic raw_e, raw_m, raw_w, raw_hazard;
  logic br_go, stall_go, halt_go;

  function automatic logic hit(input logic use_rs, input logic [REG_ADDR_W-1:0] rs,
                               input logic prod, input logic [REG_ADDR_W-1:0] rd);
    return use_rs & prod & (rs == rd);
  endfunction

  // A stage is a producer only if it holds a live instruction that writes a
  // non-zero register.
  always_comb begin
    prod_e = valid_e & wr_e & (rd_e != '0);
    prod_m = valid_m & wr_m & (rd_m != '0);
    prod_w = valid_w & wr_w & (rd_w != '0);
    raw_e  = hit(use_rs1_d, rs1_d, prod_e, rd_e) | hit(use_rs2_d, rs2_d, prod_e, rd_e);
    raw_m  = hit(use_rs1_d, rs1_d, prod_m, rd_m) | hit(use_rs2_d, rs2_d, prod_m, rd_m);
    raw_w  = hit(use_rs1_d, rs1_d, prod_w, rd_w) | hit(use_rs2_d, rs2_d, prod_w, rd_w);
    // With forwarding only a load in EX cannot be bypassed in time.
    if (FWD_ON) raw_hazard = valid_d & load_e & raw_e;
    else        raw_hazard = valid_d & (raw_e | raw_m | raw_w);
  end

  // Per-cycle flow decision, highest priority first.
  always_comb begin
    pc_wr_en      = 1'b0;
    pc_sel_target = 1'b0;
    if_id_wr_en   = 1'b0;
    id_ex_wr_en   = 1'b0;
    ex_mem_wr_en  = 1'b0;
    mem_wb_wr_en  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    br_go         = 1'b0;
    stall_go      = 1'b0;
    halt_go       = 1'b0;
    if (!((state == HALTED) || mem_stall)) begin
      if (br_taken_e && valid_e) begin
        // Redirect squashes whatever sits in IF/ID, including a HALT or a hazard.
        br_go         = 1'b1;
        pc_wr_en      = 1'b1;
        pc_sel_target = 1'b1;
        if_id_wr_en   = 1'b1;
        id_ex_wr_en   = 1'b1;
        ex_mem_wr_en  = 1'b1;
        mem_wb_wr_en  = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
      end else if (raw_hazard) begin
        // Hold PC and IF/ID, insert a bubble into EX, let older stages drain.
        stall_go     = 1'b1;
        id_ex_wr_en  = 1'b1;
        ex_mem_wr_en = 1'b1;
        mem_wb_wr_en = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (halt_d && valid_d && (state == RUN)) begin
        // HALT moves on to EX while fetch stops and IF/ID takes a bubble.
        halt_go      = 1'b1;
        if_id_wr_en  = 1'b1;
        id_ex_wr_en  = 1'b1;
        ex_mem_wr_en = 1'b1;
        mem_wb_wr_en = 1'b1;
        if_id_flush  = 1'b1;
      end else begin
        pc_wr_en     = (state == RUN);
        if_id_wr_en  = 1'b1;
        id_ex_wr_en  = 1'b1;
        ex_mem_wr_en = 1'b1;
        mem_wb_wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      valid_d <= 1'b0;
      valid_e <= 1'b0;
      valid_m <= 1'b0;
      valid_w <= 1'b0;
      halt_e  <= 1'b0;
      halt_m  <= 1'b0;
      halt_w  <= 1'b0;
      ohalt   <= 1'b0;
    end else begin
      if (if_id_wr_en) valid_d <= (state == RUN) & ~if_id_flush;
      if (id_ex_wr_en) begin
        valid_e <= valid_d & ~id_ex_flush;
        halt_e  <= halt_go;
      end
      if (ex_mem_wr_en) begin
        valid_m <= valid_e;
        halt_m  <= halt_e;
      end
      if (mem_wb_wr_en) begin
        valid_w <= valid_m;
        halt_w  <= halt_m;
      end
      if (halt_go) state <= DRAIN;
      // HALT leaving WB completes the drain.
      if ((state == DRAIN) && mem_wb_wr_en && valid_w && halt_w) begin
        state <= HALTED;
        ohalt <= 1'b1;
      end
    end
  end

  // EX operand bypass; MEM beats WB, x0 never forwards (prod_* excludes it).
  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (FWD_ON) begin
      if (prod_m && (rs1_e == rd_m))      fwd_a_sel = FWD_MEM;
      else if (prod_w && (rs1_e == rd_w)) fwd_a_sel = FWD_WB;
      if (prod_m && (rs2_e == rd_m))      fwd_b_sel = FWD_MEM;
      else if (prod_w && (rs2_e == rd_w)) fwd_b_sel = FWD_WB;
    end
  end

  assign state_dbg = state;

  sat_counter #(.WIDTH(CNT_W)) u_cyc_cnt (
    .clk(clk), .rst(rst), .inc(state != HALTED), .q(cyc_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall_go), .q(stall_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(br_go), .q(flush_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
    .clk(clk), .rst(rst), .inc(valid_w & mem_wb_wr_en), .q(retire_cnt)
  );

endmodule
